// File: rtl/hs_ram_arbiter.sv
// hs_ram_arbiter: hands the shared work RAM from the game CPU to the
// high-score engine. The CPU is paused, the bus is allowed to settle, and
// only then is the high-score port granted. A watchdog forces the grant
// when the CPU never reports an idle bus boundary.
module hs_ram_arbiter #(
  parameter int unsigned SETTLE_CYC  = 4,
  parameter logic [15:0] TIMEOUT_CYC = 16'd4800
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ext_pause,
  input  logic        cpu_idle,
  output logic        cpu_pause_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  output logic [7:0]  cpu_rdata,
  input  logic        hs_req,
  input  logic [15:0] hs_addr,
  input  logic [7:0]  hs_wdata,
  input  logic        hs_we,
  output logic        hs_grant,
  output logic [7:0]  hs_rdata,
  output logic        hs_timeout,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_GRANT   = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  // Terminal counts: the wait counter starts at 0 on entry to a state.
  localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYC - 32'd1);
  localparam logic [15:0] TIMEOUT_LAST = TIMEOUT_CYC - 16'd1;

  state_t      state_r;
  state_t      state_s;
  logic        set_timeout_s;
  logic        cnt_clear_s;
  logic        pause_state_s;
  logic        grant_sel_s;
  logic [15:0] wait_cnt_r;
  logic        cpu_pause_n_r;
  logic        hs_grant_r;
  logic [7:0]  hs_rdata_r;
  logic        hs_timeout_r;

  // Next-state decode; a dropped request always wins over progress.
  always_comb begin
    state_s       = state_r;
    set_timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (hs_req) state_s = ST_HOLD;
        else        state_s = ST_IDLE;
      end
      ST_HOLD: begin
        if (!hs_req) begin
          state_s = ST_RELEASE;
        end else if (cpu_idle) begin
          state_s = ST_SETTLE;
        end else if (wait_cnt_r == TIMEOUT_LAST) begin
          state_s       = ST_SETTLE;
          set_timeout_s = 1'b1;
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_SETTLE: begin
        if (!hs_req)                        state_s = ST_RELEASE;
        else if (wait_cnt_r == SETTLE_LAST) state_s = ST_GRANT;
        else                                state_s = ST_SETTLE;
      end
      ST_GRANT: begin
        if (hs_req) state_s = ST_GRANT;
        else        state_s = ST_RELEASE;
      end
      ST_RELEASE: state_s = ST_IDLE;
      default:    state_s = ST_IDLE;
    endcase
  end

  assign cnt_clear_s   = (state_s != state_r) &&
                         ((state_s == ST_HOLD) || (state_s == ST_SETTLE));
  assign pause_state_s = (state_s == ST_HOLD) || (state_s == ST_SETTLE) ||
                         (state_s == ST_GRANT);
  assign grant_sel_s   = (state_r == ST_GRANT);

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_s;
  end

  // Wait counter: cleared on entry to HOLD/SETTLE, saturates at all-ones.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                    wait_cnt_r <= 16'd0;
    else if (cnt_clear_s)            wait_cnt_r <= 16'd0;
    else if (wait_cnt_r != 16'hFFFF) wait_cnt_r <= wait_cnt_r + 16'd1;
    else                             wait_cnt_r <= wait_cnt_r;
  end

  // Registered pause and grant, decoded from the state being entered.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cpu_pause_n_r <= 1'b1;
      hs_grant_r    <= 1'b0;
    end else begin
      cpu_pause_n_r <= ~(pause_state_s | ext_pause);
      hs_grant_r    <= (state_s == ST_GRANT);
    end
  end

  // High-score read data, captured only while the engine owns the RAM.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)         hs_rdata_r <= 8'h00;
    else if (grant_sel_s) hs_rdata_r <= ram_rdata;
    else                  hs_rdata_r <= hs_rdata_r;
  end

  // Sticky record that a grant was forced by the watchdog.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)           hs_timeout_r <= 1'b0;
    else if (set_timeout_s) hs_timeout_r <= 1'b1;
    else                    hs_timeout_r <= hs_timeout_r;
  end

  // RAM mux follows the current state so a reset hands the bus back at once.
  assign ram_addr    = grant_sel_s ? hs_addr  : cpu_addr;
  assign ram_wdata   = grant_sel_s ? hs_wdata : cpu_wdata;
  assign ram_we      = grant_sel_s ? hs_we    : cpu_we;
  assign cpu_rdata   = ram_rdata;

  assign cpu_pause_n = cpu_pause_n_r;
  assign hs_grant    = hs_grant_r;
  assign hs_rdata    = hs_rdata_r;
  assign hs_timeout  = hs_timeout_r;

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Bench for hs_ram_arbiter: directed sessions followed by randomized traffic,
// all checked cycle by cycle against a phase/cycle-count reference model and
// a reference copy of the shared RAM.
module tb_hs_ram_arbiter;

  localparam int TB_SETTLE = 4;
  localparam int TB_TMO    = 16;

  localparam int P_IDLE = 0, P_HOLD = 1, P_SETTLE = 2, P_GRANT = 3, P_REL = 4;

  logic        clk_sys, reset_n, ext_pause, cpu_idle, cpu_pause_n;
  logic [15:0] cpu_addr, hs_addr, ram_addr;
  logic [7:0]  cpu_wdata, cpu_rdata, hs_wdata, hs_rdata, ram_wdata, ram_rdata;
  logic        cpu_we, hs_req, hs_we, hs_grant, hs_timeout, ram_we;

  hs_ram_arbiter #(.SETTLE_CYC(TB_SETTLE), .TIMEOUT_CYC(16'd16)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ext_pause(ext_pause),
    .cpu_idle(cpu_idle), .cpu_pause_n(cpu_pause_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_rdata(cpu_rdata), .hs_req(hs_req), .hs_addr(hs_addr),
    .hs_wdata(hs_wdata), .hs_we(hs_we), .hs_grant(hs_grant),
    .hs_rdata(hs_rdata), .hs_timeout(hs_timeout), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Shared synchronous RAM attached to the DUT (read-before-write).
  logic [7:0] bram [0:65535];
  logic       mem_clr;
  always @(posedge clk_sys) begin
    if (mem_clr) begin
      for (int a = 0; a < 65536; a++) bram[a] <= 8'h00;
      ram_rdata <= 8'h00;
    end else begin
      if (ram_we) bram[ram_addr] <= ram_wdata;
      ram_rdata <= bram[ram_addr];
    end
  end

  // Reference model state.
  logic [7:0] ref_mem [0:65535];
  logic [7:0] ref_rdata, m_hs_rdata;
  int         m_phase, m_hold_n, m_settle_n;
  bit         m_tout, m_pause_n, m_grant;
  int         n_vec, n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_hold_n = 0; m_settle_n = 0; m_tout = 1'b0;
    m_hs_rdata = 8'h00; m_pause_n = 1'b1; m_grant = 1'b0;
  endtask

  // One clock cycle: check the RAM mux, clock, advance the model, check registers.
  task automatic step();
    logic [15:0] ea;
    logic [7:0]  ew, rd_next;
    logic        ewe;
    bit          own;
    #1;
    own = (m_phase == P_GRANT);
    ea  = own ? hs_addr  : cpu_addr;
    ew  = own ? hs_wdata : cpu_wdata;
    ewe = own ? hs_we    : cpu_we;
    chk("ram_addr",  32'(ram_addr),  32'(ea));
    chk("ram_wdata", 32'(ram_wdata), 32'(ew));
    chk("ram_we",    32'(ram_we),    32'(ewe));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(ref_rdata));
    @(posedge clk_sys);
    if (reset_n && own) m_hs_rdata = ref_rdata;
    rd_next = ref_mem[ea];
    if (ewe) ref_mem[ea] = ew;
    ref_rdata = rd_next;
    if (!reset_n) begin
      model_reset();
    end else begin
      case (m_phase)
        P_IDLE: if (hs_req) begin m_phase = P_HOLD; m_hold_n = 1; end
        P_HOLD: begin
          if (!hs_req) m_phase = P_REL;
          else if (cpu_idle) begin m_phase = P_SETTLE; m_settle_n = 1; end
          else if (m_hold_n >= TB_TMO) begin
            m_phase = P_SETTLE; m_settle_n = 1; m_tout = 1'b1;
          end else m_hold_n++;
        end
        P_SETTLE: begin
          if (!hs_req) m_phase = P_REL;
          else if (m_settle_n >= TB_SETTLE) m_phase = P_GRANT;
          else m_settle_n++;
        end
        P_GRANT: if (!hs_req) m_phase = P_REL;
        default: m_phase = P_IDLE;
      endcase
      m_pause_n = !(ext_pause || m_phase == P_HOLD || m_phase == P_SETTLE ||
                    m_phase == P_GRANT);
      m_grant   = (m_phase == P_GRANT);
    end
    #1;
    chk("cpu_pause_n", 32'(cpu_pause_n), 32'(m_pause_n));
    chk("hs_grant",    32'(hs_grant),    32'(m_grant));
    chk("hs_timeout",  32'(hs_timeout),  32'(m_tout));
    chk("hs_rdata",    32'(hs_rdata),    32'(m_hs_rdata));
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    reset_n = 1'b0; ext_pause = 1'b0; cpu_idle = 1'b0; hs_req = 1'b0;
    cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_we = 1'b0;
    hs_addr = 16'h0000; hs_wdata = 8'h00; hs_we = 1'b0;
    mem_clr = 1'b1;
    for (int a = 0; a < 65536; a++) ref_mem[a] = 8'h00;
    ref_rdata = 8'h00;
    model_reset();
    @(posedge clk_sys); #1;
    mem_clr = 1'b0;

    // Reset values.
    chk("rst_pause_n", 32'(cpu_pause_n), 32'd1);
    chk("rst_grant",   32'(hs_grant),    32'd0);
    chk("rst_rdata",   32'(hs_rdata),    32'd0);
    chk("rst_timeout", 32'(hs_timeout),  32'd0);
    step(); step();
    reset_n = 1'b1;
    step();

    // Normal session: request at cycle 0, CPU idle from cycle 3.
    hs_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) chk("ses_pause_c1", 32'(cpu_pause_n), 32'd0);
      if (c == 3) cpu_idle = 1'b1;
      if (c == 7) chk("ses_grant_c7", 32'(hs_grant), 32'd0);
      if (c == 8) chk("ses_grant_c8", 32'(hs_grant), 32'd1);
    end
    cpu_idle = 1'b0;
    chk("ses_timeout", 32'(hs_timeout), 32'd0);

    // Write 0xA5 to 0x0C10 then read it back through the high-score port.
    hs_addr = 16'h0C10; hs_wdata = 8'hA5; hs_we = 1'b1;
    step();
    hs_we = 1'b0;
    step();
    chk("wr_ram_0c10", 32'(bram[16'h0C10]), 32'hA5);
    chk("rd_cpu_rdata", 32'(cpu_rdata), 32'hA5);
    step();
    chk("rd_hs_rdata", 32'(hs_rdata), 32'hA5);

    // CPU write during GRANT is dropped.
    cpu_we = 1'b1; cpu_addr = 16'h0000; cpu_wdata = 8'h5A;
    step();
    cpu_we = 1'b0;
    chk("iso_cpu_we", 32'(bram[16'h0000]), 32'h00);
    hs_req = 1'b0;
    step(); step();

    // High-score write during HOLD is dropped.
    hs_req = 1'b1; hs_we = 1'b1; hs_addr = 16'h0C20; hs_wdata = 8'h77;
    for (int c = 0; c < 4; c++) step();
    chk("iso_hs_we", 32'(bram[16'h0C20]), 32'h00);
    hs_we = 1'b0; hs_req = 1'b0;
    step(); step();

    // Watchdog: CPU never idle, 16 HOLD cycles then SETTLE.
    hs_req = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      step();
      if (c == 16) chk("tmo_c16", 32'(hs_timeout), 32'd0);
      if (c == 17) chk("tmo_c17", 32'(hs_timeout), 32'd1);
      if (c == 21) chk("tmo_grant", 32'(hs_grant), 32'd1);
    end
    hs_req = 1'b0;
    step(); step(); step();
    chk("tmo_sticky", 32'(hs_timeout), 32'd1);

    // Abort in SETTLE, request held through RELEASE.
    hs_req = 1'b1; cpu_idle = 1'b1;
    step(); step(); step();
    hs_req = 1'b0;
    step();
    chk("abort_rel_pause", 32'(cpu_pause_n), 32'd1);
    hs_req = 1'b1;
    step();
    chk("abort_idle_pause", 32'(cpu_pause_n), 32'd1);
    step();
    chk("abort_hold_pause", 32'(cpu_pause_n), 32'd0);
    for (int c = 0; c < 5; c++) step();
    chk("b2b_grant", 32'(hs_grant), 32'd1);

    // Reset while granted: outputs drop without a clock edge.
    hs_we = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    reset_n = 1'b0;
    #1;
    chk("rstg_grant", 32'(hs_grant),    32'd0);
    chk("rstg_pause", 32'(cpu_pause_n), 32'd1);
    chk("rstg_we",    32'(ram_we),      32'd0);
    chk("rstg_addr",  32'(ram_addr),    32'h1234);
    model_reset();
    step(); step();
    hs_req = 1'b0; hs_we = 1'b0; cpu_idle = 1'b0;
    reset_n = 1'b1;
    step(); step();
    chk("rstg_idle_grant", 32'(hs_grant), 32'd0);

    // Randomized traffic with occasional mid-run resets.
    for (int i = 0; i < 4000; i++) begin
      if (($urandom % 12) == 0) hs_req = ~hs_req;
      cpu_idle  = ($urandom_range(0, 3) == 0);
      ext_pause = ($urandom_range(0, 15) == 0);
      cpu_we    = ($urandom_range(0, 2) == 0);
      hs_we     = ($urandom_range(0, 2) == 0);
      cpu_addr  = 16'h0C00 | 16'($urandom_range(0, 7));
      hs_addr   = 16'h0C00 | 16'($urandom_range(0, 7));
      cpu_wdata = 8'($urandom);
      hs_wdata  = 8'($urandom);
      if ((i % 1000) == 999) begin
        reset_n = 1'b0;
        #1;
        chk("rnd_rst_grant", 32'(hs_grant), 32'd0);
        model_reset();
        step();
        reset_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hs_ram_arbiter.md
HS_RAM_ARBITER -- requirements
Module: hs_ram_arbiter

Interface
REQ-001 Parameter SETTLE_CYC, default 4: cycles the CPU is held paused after idle acknowledge before the high-score port is granted (range 1..15).
REQ-002 Parameter TIMEOUT_CYC, default 16'd4800: maximum cycles spent waiting for cpu_idle before a forced grant (range 1..65535).
REQ-003 clk_sys  in  1  single clock (48 MHz system clock); all logic on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 ext_pause  in  1  merged user/OSD pause request, level.
REQ-006 cpu_idle  in  1  CPU core at a safe bus boundary with no RAM cycle in flight, level.
REQ-007 cpu_pause_n  out  1  pause to game core, active-low.
REQ-008 cpu_addr, cpu_wdata, cpu_we  in  16/8/1  CPU work-RAM port.
REQ-009 cpu_rdata  out  8  CPU read data.
REQ-010 hs_req  in  1  high-score engine requests RAM ownership, level.
REQ-011 hs_addr, hs_wdata, hs_we  in  16/8/1  high-score RAM port.
REQ-012 hs_grant  out  1  high-score engine owns RAM.
REQ-013 hs_rdata  out  8  high-score read data, registered.
REQ-014 hs_timeout  out  1  sticky flag: a grant was forced by timeout.
REQ-015 ram_addr, ram_wdata, ram_we  out  16/8/1  shared synchronous RAM port (read data one cycle after address).
REQ-016 ram_rdata  in  8  shared RAM read data.

Function
REQ-017 The block SHALL implement the states IDLE, HOLD, SETTLE, GRANT and RELEASE, one-hot or binary, registered.
REQ-018 IDLE: hs_req=1 -> HOLD on the next edge; otherwise stay.
REQ-019 HOLD: cpu_idle=1 -> SETTLE; wait counter reaching TIMEOUT_CYC-1 with cpu_idle=0 -> SETTLE and set hs_timeout; hs_req=0 -> RELEASE (abort).
REQ-020 SETTLE: remains exactly SETTLE_CYC cycles, then -> GRANT; hs_req=0 -> RELEASE (abort).
REQ-021 GRANT: stays while hs_req=1; hs_req=0 -> RELEASE.
REQ-022 RELEASE: lasts exactly 1 cycle -> IDLE; a hs_req held or reasserted meanwhile does not shorten it.
REQ-023 cpu_pause_n SHALL be registered: 0 in HOLD, SETTLE and GRANT, or whenever ext_pause=1; otherwise 1.
REQ-024 After GRANT ends, cpu_pause_n SHALL be 1 for at least 2 cycles (RELEASE + IDLE) before a new HOLD, unless ext_pause=1.
REQ-025 hs_grant SHALL be registered and equal to 1 exactly while in GRANT.
REQ-026 RAM mux select SHALL be (state==GRANT): if selected, ram_addr/ram_wdata come from hs_*, else from cpu_*; combinational.
REQ-027 ram_we SHALL be hs_we in GRANT and cpu_we in every other state; hs_we outside GRANT never reaches the RAM; cpu_we in GRANT is dropped.
REQ-028 cpu_rdata SHALL be ram_rdata passed through combinationally in all states.
REQ-029 hs_rdata SHALL capture ram_rdata on every edge in GRANT and hold its value otherwise; it reflects the hs_addr presented 2 cycles earlier.
REQ-030 The wait counter (16 bit) SHALL clear on entry to HOLD and SETTLE, and saturate rather than wrap.
REQ-031 hs_timeout SHALL stay 1 once set until reset.
REQ-032 ext_pause SHALL NOT alter state transitions; cpu_idle resulting from ext_pause is accepted normally.

Reset
REQ-033 While reset_n=0 the block SHALL hold: state IDLE, cpu_pause_n=1 (or 0 if ext_pause=1 after the first edge out of reset), hs_grant=0, hs_rdata=8'h00, hs_timeout=0, counters 0.
REQ-034 Reset asserted mid-session SHALL return to IDLE immediately with hs_grant=0 and RAM ownership back to the CPU.

Verification
REQ-035 Normal session: hs_req=1 at cycle 0, cpu_idle=1 from cycle 3 -> cpu_pause_n=0 at cycle 1; SETTLE cycles 4-7; hs_grant=1 at cycle 8; hs_timeout=0.
REQ-036 Write/read: in GRANT write 8'hA5 to 16'h0C10, then read 16'h0C10 -> RAM shows 8'hA5; hs_rdata=8'hA5 two cycles after the read address is presented.
REQ-037 Timeout: hs_req=1, cpu_idle=0 forever, TIMEOUT_CYC=16 -> SETTLE entered after 16 HOLD cycles; hs_timeout=1 and stays 1 after release.
REQ-038 Abort and back-to-back: drop hs_req in SETTLE -> RELEASE, IDLE, cpu_pause_n=1 for >=2 cycles; hs_req held through RELEASE -> new HOLD follows.
REQ-039 Isolation: cpu_we=1 to 16'h0000 during GRANT -> RAM unchanged; hs_we=1 during HOLD -> RAM unchanged.
REQ-040 Reset mid-GRANT: drive reset_n=0 -> hs_grant=0 and cpu_pause_n=1 without a clock edge; state IDLE after release.
